// File: rtl/ifns_decode_arbiter.sv
// rtl/ifns_decode_arbiter.sv - round-robin sharing of one IFNS 26->18 decoder among NUM_CH channels
// Output register holds decoded word plus source channel; saturating output-stall counter.

module decoderIFNS_18di_core (
    input  logic [25:0] code,
    output logic [17:0] data
);
    // Fibonacci-weighted sum (weights 1,1,2,3,5,...), taken modulo 2**18
    logic [17:0] wa;
    logic [17:0] wb;
    logic [17:0] wt;

    always_comb begin
        data = '0;
        wa   = 18'd1;
        wb   = 18'd1;
        wt   = '0;
        for (int i = 0; i < 26; i++) begin
            if (code[i]) data = data + wa;
            wt = wa + wb;
            wa = wb;
            wb = wt;
        end
    end
endmodule

module ifns_decode_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ID_W    = 2,
    parameter int STALL_W = 16
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*26-1:0] in_code,
    output logic [NUM_CH-1:0]    in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [17:0]          out_data,
    output logic [ID_W-1:0]      out_ch,
    output logic [STALL_W-1:0]   stall_cnt,
    input  logic                 stall_clr
);
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gidx;
    logic [ID_W-1:0]   cur;
    logic [ID_W:0]     scan;
    logic              found;
    logic              can_load;
    logic [25:0]       sel_code;
    logic [17:0]       dec_data;

    assign req      = in_valid & ch_en;
    assign can_load = ~out_valid | out_ready;

    // First requester at or after ptr, wrapping NUM_CH-1 -> 0
    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        cur   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_CH)) scan = scan - (ID_W+1)'(NUM_CH);
            cur = scan[ID_W-1:0];
            if (!found && req[cur]) begin
                found      = 1'b1;
                gidx       = cur;
                grant[cur] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_code = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) sel_code = in_code[26*c +: 26];
        end
    end

    assign in_ready = (rst_n && can_load) ? grant : '0;

    decoderIFNS_18di_core u_core (
        .code (sel_code),
        .data (dec_data)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
            stall_cnt <= '0;
        end else begin
            if (can_load) begin
                if (found) begin
                    out_valid <= 1'b1;
                    out_data  <= dec_data;
                    out_ch    <= gidx;
                    ptr       <= (gidx == ID_W'(NUM_CH-1)) ? '0 : gidx + 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (stall_clr)
                stall_cnt <= '0;
            else if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ifns_decode_arbiter.sv
// tb/tb_ifns_decode_arbiter.sv - randomized self-checking bench for ifns_decode_arbiter

module tb_ifns_decode_arbiter;
    localparam int N = 4;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [N-1:0]  ch_en;
    logic [N-1:0]  in_valid;
    logic [N*26-1:0] in_code;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [17:0]   out_data;
    logic [1:0]    out_ch;
    logic [2:0]    stall_cnt;
    logic          stall_clr;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_valid, m_data, m_ch, m_ptr, m_stall;

    always #5 clock = ~clock;

    ifns_decode_arbiter #(.NUM_CH(N), .ID_W(2), .STALL_W(3)) dut (
        .clock(clock), .rst_n(rst_n), .ch_en(ch_en), .in_valid(in_valid),
        .in_code(in_code), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    function automatic int ref_decode(input logic [25:0] c);
        int f0, f1, t, s;
        f0 = 1; f1 = 1; s = 0;
        for (int i = 0; i < 26; i++) begin
            if (c[i]) s += f0;
            t = f0 + f1; f0 = f1; f1 = t;
        end
        return s % 262144;
    endfunction

    function automatic int exp_grant();
        if (m_valid != 0 && !out_ready) return -1;
        for (int k = 0; k < N; k++)
            if (in_valid[(m_ptr + k) % N] && ch_en[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_stall = 0;
    endtask

    // called at the active edge, before inputs change
    task automatic model_edge();
        int g;
        logic [25:0] c;
        g = exp_grant();
        if (stall_clr) m_stall = 0;
        else if (m_valid != 0 && !out_ready && m_stall < 7) m_stall++;
        if (m_valid == 0 || out_ready) begin
            if (g >= 0) begin
                c = in_code[26*g +: 26];
                m_valid = 1; m_data = ref_decode(c); m_ch = g; m_ptr = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic rand_codes();
        for (int c = 0; c < N; c++) in_code[26*c +: 26] = 26'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_en = '1; in_valid = '1; out_ready = 1'b1; stall_clr = 1'b0;
        rand_codes();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || stall_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b stall_cnt=%0d required 0/0000/0",
                     out_valid, in_ready, stall_cnt);
        end
        rst_n = 1'b1;
        #3;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_grant: in_ready=%b required 0001", in_ready);
        end
        @(posedge clock); model_edge(); #1;
    endtask

    task automatic test_single();
        for (int i = 0; i < 24; i++) begin
            in_valid = 4'b0100; ch_en = '1; out_ready = 1'b1; stall_clr = 1'b0;
            rand_codes();
            if (i == 0) in_code[52 +: 26] = 26'h0;
            if (i > 0) in_valid = N'(1 << $urandom_range(N-1));
            #3;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL single_grant: in_ready=%b required %b", in_ready, exp_ready());
            end
            @(posedge clock); model_edge(); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== 2'(m_ch) || out_data !== 18'(m_data)) begin
                miscompares++;
                $display("FAIL single_out: valid=%b ch=%0d data=%h required 1/%0d/%h",
                         out_valid, out_ch, out_data, m_ch, m_data);
            end
        end
    endtask

    task automatic test_round_robin();
        int start;
        start = m_ptr;
        for (int i = 0; i < 6; i++) begin
            in_valid = '1; ch_en = '1; out_ready = 1'b1; stall_clr = 1'b0;
            rand_codes();
            #3;
            vectors++;
            if (in_ready !== N'(1 << ((start + i) % N))) begin
                miscompares++;
                $display("FAIL rr_grant: in_ready=%b required %b", in_ready, N'(1 << ((start + i) % N)));
            end
            @(posedge clock); model_edge(); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== 2'((start + i) % N) || out_data !== 18'(m_data)) begin
                miscompares++;
                $display("FAIL rr_out: valid=%b ch=%0d data=%h required 1/%0d/%h",
                         out_valid, out_ch, out_data, (start + i) % N, m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] held_data;
        logic [1:0]  held_ch;
        in_valid = '1; ch_en = '1; out_ready = 1'b1; stall_clr = 1'b1;
        rand_codes();
        @(posedge clock); model_edge(); #1;
        held_data = out_data; held_ch = out_ch;
        stall_clr = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_codes();
            #3;
            vectors++;
            if (in_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_ready: in_ready=%b required 0000", in_ready);
            end
            @(posedge clock); model_edge(); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_ch !== held_ch || out_data !== 18'(m_data)) begin
                miscompares++;
                $display("FAIL bp_hold: valid=%b ch=%0d data=%h required 1/%0d/%h",
                         out_valid, out_ch, out_data, held_ch, held_data);
            end
        end
        vectors++;
        if (stall_cnt !== 3'd5 || m_stall != 5) begin
            miscompares++;
            $display("FAIL bp_stall_cnt: stall_cnt=%0d required 5", stall_cnt);
        end
        stall_clr = 1'b1;
        @(posedge clock); model_edge(); #1;
        stall_clr = 1'b0;
        vectors++;
        if (stall_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL bp_stall_clr: stall_cnt=%0d required 0", stall_cnt);
        end
        repeat (9) begin
            @(posedge clock); model_edge(); #1;
        end
        vectors++;
        if (stall_cnt !== 3'd7 || m_stall != 7) begin
            miscompares++;
            $display("FAIL stall_saturate: stall_cnt=%0d required 7", stall_cnt);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_mask();
        for (int i = 0; i < 12; i++) begin
            ch_en = 4'b1010; out_ready = 1'b1; stall_clr = 1'b0;
            in_valid = (i < 6) ? 4'b1111 : 4'b0111;
            rand_codes();
            #3;
            vectors++;
            if (in_ready !== exp_ready() || (in_ready & 4'b0101) != 0 || (i >= 7 && in_ready !== 4'b0010)) begin
                miscompares++;
                $display("FAIL mask_grant: in_ready=%b required %b", in_ready, exp_ready());
            end
            @(posedge clock); model_edge(); #1;
            vectors++;
            if (out_valid !== 1'(m_valid) || out_ch !== 2'(m_ch) || out_data !== 18'(m_data)) begin
                miscompares++;
                $display("FAIL mask_out: valid=%b ch=%0d data=%h required %0d/%0d/%h",
                         out_valid, out_ch, out_data, m_valid, m_ch, m_data);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ch_en = N'($urandom); in_valid = N'($urandom);
            out_ready = ($urandom_range(3) != 0); stall_clr = ($urandom_range(15) == 0);
            rand_codes();
            #3;
            vectors++;
            if (in_ready !== exp_ready()) begin
                miscompares++;
                $display("FAIL rand_grant: cycle %0d in_ready=%b required %b", i, in_ready, exp_ready());
            end
            @(posedge clock); model_edge(); #1;
            vectors++;
            if (out_valid !== 1'(m_valid) || stall_cnt !== 3'(m_stall) ||
                (m_valid != 0 && (out_ch !== 2'(m_ch) || out_data !== 18'(m_data)))) begin
                miscompares++;
                $display("FAIL rand_out: cycle %0d valid=%b ch=%0d data=%h stall=%0d required %0d/%0d/%h/%0d",
                         i, out_valid, out_ch, out_data, stall_cnt, m_valid, m_ch, m_data, m_stall);
            end
        end
        stall_clr = 1'b0;
    endtask

    task automatic test_mid_reset();
        ch_en = '1; in_valid = 4'b0100; out_ready = 1'b1;
        rand_codes();
        @(posedge clock); model_edge(); #1;
        in_valid = '1; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || stall_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset_clear: out_valid=%b in_ready=%b stall=%0d required 0/0000/0",
                     out_valid, in_ready, stall_cnt);
        end
        @(posedge clock); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        #3;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL midreset_first_grant: in_ready=%b required 0001", in_ready);
        end
        @(posedge clock); model_edge(); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 18'(m_data)) begin
            miscompares++;
            $display("FAIL midreset_out: valid=%b ch=%0d data=%h required 1/0/%h",
                     out_valid, out_ch, out_data, m_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
